bus_responder: RTL

- Memory-mapped target on the hmc-6502 external bus; the CPU-side tristate drivers and bus latches are the initiator end.
- Claims an address window and serves byte reads and writes from an internal RAM.
- Inserts a programmable number of wait states by deasserting rdy.
- Drives the shared bidirectional data bus only during its own read-completion cycle.

---
 rtl/bus_responder_pkg.sv | 15 +
 rtl/resp_ram.sv | 30 +++
 rtl/bus_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the bus_responder target.
//   resp_state_t : responder FSM states (IDLE, WAIT, DONE)
//   RW_READ/RW_WRITE : encoding of the initiator rw strobe
package bus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/resp_ram.sv
// Byte array backing the responder window. Single port: synchronous write,
// combinational read. No reset, so contents survive a responder reset.
//   clk_i   : write clock
//   we_i    : write enable
//   addr_i  : byte index (shared by read and write)
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
module resp_ram #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [7:0]           wdata_i,
  output logic [7:0]           rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped target on the external bus. Claims the 2**ADDR_BITS byte
// window at BASE, serves byte reads/writes from resp_ram, holds rdy low for
// WAIT_STATES cycles, and drives data_bus only in a read-completion cycle.
//   clk      : system clock
//   reset    : synchronous active-high reset
//   req      : bus-cycle strobe
//   rw       : 1 = read, 0 = write
//   addr     : byte address
//   data_bus : shared bidirectional data bus
//   rdy      : 0 while in a wait state
//   hit      : 1 while a claimed transaction is in flight
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter logic [15:0] BASE        = 16'h0000,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data_bus,
  output logic        rdy,
  output logic        hit
);

  // Counter reload; WAIT is never entered when WAIT_STATES is 0.
  localparam logic [3:0] WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic                 rw_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [7:0]           wdata_q;

  logic       in_win;
  logic       accept;
  logic       latch_en;
  logic       ram_we;
  logic       drive_en;
  logic [7:0] ram_rdata;

  assign in_win = (addr[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
  assign accept = req && in_win && (state_q != WAIT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          latch_en = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = WaitLoad;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= RW_WRITE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        rw_q  <= rw;
        idx_q <= addr[ADDR_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en && (rw == RW_WRITE)) begin
      wdata_q <= data_bus;
    end
  end

  // Write commits at the edge that ends DONE; a reset at that edge cancels it.
  assign ram_we   = (state_q == DONE) && (rw_q == RW_WRITE) && !reset;
  assign drive_en = (state_q == DONE) && (rw_q == RW_READ);

  resp_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  assign data_bus = drive_en ? ram_rdata : {8{1'bz}};
  assign rdy      = (state_q != WAIT);
  assign hit      = (state_q != IDLE);

endmodule
